seqpu_mem_responder: RTL and testbench

Memory-side responder for the seqpu CPU bus: it answers the CPU's `address`/`data_out`/`wren_n`/`oen_n` strobes with zero-wait-state reads and clocked writes. It sits between the CPU and the outside world. It holds a word-addressed RAM plus a small I/O page containing an output FIFO drained by a valid/ready stream, a free-running timer, and status/error flags.

---
 rtl/seqpu_pkg.sv | 38 +++
 rtl/seqpu_out_fifo.sv | 61 ++++++
 rtl/seqpu_mem_responder.sv | 122 ++++++++++++
 tb/tb_seqpu_mem_responder.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/seqpu_pkg.sv
// Shared constants for the seqpu memory-side responder: I/O page base,
// register offsets and STATUS bit layout, plus a helper that packs STATUS.
// Pure definitions, no ports.
package seqpu_pkg;

  // I/O page occupies 0xFF00..0xFFFF; only the upper byte is decoded.
  localparam logic [15:0] IO_BASE = 16'hFF00;

  localparam logic [7:0] REG_OUT     = 8'h00;
  localparam logic [7:0] REG_STATUS  = 8'h01;
  localparam logic [7:0] REG_TIMER   = 8'h02;
  localparam logic [7:0] REG_SCRATCH = 8'h03;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_BUSERR  = 3;
  localparam int ST_CNT_LSB = 4;
  localparam int ST_CNT_W   = 5;

  function automatic logic [15:0] pack_status(
    input logic                full,
    input logic                empty,
    input logic                ovf,
    input logic                berr,
    input logic [ST_CNT_W-1:0] cnt
  );
    logic [15:0] s;
    s = '0;
    s[ST_FULL]                   = full;
    s[ST_EMPTY]                  = empty;
    s[ST_OVF]                    = ovf;
    s[ST_BUSERR]                 = berr;
    s[ST_CNT_LSB +: ST_CNT_W]    = cnt;
    return s;
  endfunction

endpackage

// File: rtl/seqpu_out_fifo.sv
// Synchronous FIFO with push/pop, full/empty/count and push-while-full-with-pop.
// Latency: pushed word visible at head one cycle after the push edge (no read-through).
// Backpressure: a push while full is rejected (ovf_evt pulses) unless a pop happens in the same cycle.
// Ports: clk, rst (sync, active-high), push/push_data, pop (ignored when empty),
//        head_data (0 when empty), full, empty, count, ovf_evt.
module seqpu_out_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 16,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          ovf_evt
);

  logic [W-1:0]  store [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_pop;
  logic          do_push;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push && (!full || do_pop);
  assign ovf_evt = push && full && !do_pop;

  assign head_data = empty ? '0 : store[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      store[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/seqpu_mem_responder.sv
// Memory-side responder for the seqpu bus: word RAM plus I/O page (OUT FIFO, STATUS, TIMER, SCRATCH).
// Latency: reads are combinational (0 cycles); writes commit at the strobe edge, visible next cycle.
// Backpressure: out_valid/out_ready stream drains the FIFO; pushes to a full FIFO set overflow.
// Ports: clk, rst (sync, active-high); CPU side address/data_out/data_in/wren_n/oen_n;
//        stream side out_data/out_valid/out_ready; bus_err sticky conflict flag.
module seqpu_mem_responder
  import seqpu_pkg::*;
#(
  parameter int    RAM_WORDS  = 4096,
  parameter int    FIFO_DEPTH = 8,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] address,
  input  logic [15:0] data_out,
  output logic [15:0] data_in,
  input  logic        wren_n,
  input  logic        oen_n,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        bus_err
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [15:0] ram [RAM_WORDS];

  logic          ram_hit;
  logic          io_hit;
  logic [7:0]    io_off;
  logic          wr_ok;
  logic          bus_conflict;
  logic          ram_we;
  logic          push;
  logic          status_we;
  logic          timer_we;
  logic          scratch_we;
  logic [15:0]   timer;
  logic [15:0]   scratch;
  logic          overflow;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          fifo_ovf;
  logic [15:0]   rdata;

  assign ram_hit = ({1'b0, address} < 17'(RAM_WORDS));
  assign io_hit  = (address[15:8] == IO_BASE[15:8]);
  assign io_off  = address[7:0];

  // Simultaneous strobes: read wins, write is dropped and flagged.
  assign bus_conflict = !wren_n && !oen_n;
  assign wr_ok        = !wren_n && oen_n && !rst;

  assign ram_we     = wr_ok && ram_hit;
  assign push       = wr_ok && io_hit && (io_off == REG_OUT);
  assign status_we  = wr_ok && io_hit && (io_off == REG_STATUS);
  assign timer_we   = wr_ok && io_hit && (io_off == REG_TIMER);
  assign scratch_we = wr_ok && io_hit && (io_off == REG_SCRATCH);

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[address[AW-1:0]] <= data_out;
    end
  end

  seqpu_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (16)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (data_out),
    .pop       (out_ready),
    .head_data (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .ovf_evt   (fifo_ovf)
  );

  assign out_valid = !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      timer    <= '0;
      scratch  <= '0;
      overflow <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      timer <= timer_we ? data_out : timer + 16'd1;
      if (scratch_we) scratch <= data_out;
      // New error events take priority over a STATUS clear in the same cycle.
      if (fifo_ovf)       overflow <= 1'b1;
      else if (status_we) overflow <= 1'b0;
      if (bus_conflict)   bus_err <= 1'b1;
      else if (status_we) bus_err <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    if (ram_hit) begin
      rdata = ram[address[AW-1:0]];
    end else if (io_hit) begin
      case (io_off)
        REG_STATUS:  rdata = pack_status(fifo_full, fifo_empty, overflow, bus_err,
                                         ST_CNT_W'(fifo_count));
        REG_TIMER:   rdata = timer;
        REG_SCRATCH: rdata = scratch;
        default:     rdata = '0;
      endcase
    end
  end

  assign data_in = oen_n ? 16'h0000 : rdata;

endmodule

// File: tb/tb_seqpu_mem_responder.sv
module tb_seqpu_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] address;
  logic [15:0] data_out;
  logic [15:0] data_in;
  logic        wren_n;
  logic        oen_n;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        bus_err;

  int checks = 0;
  int errors = 0;
  logic [15:0] q[$];

  always #5 clk = ~clk;

  seqpu_mem_responder dut (
    .clk       (clk),
    .rst       (rst),
    .address   (address),
    .data_out  (data_out),
    .data_in   (data_in),
    .wren_n    (wren_n),
    .oen_n     (oen_n),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bus_err   (bus_err)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
    logic        wn;
    logic        on;
    logic        ck;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One bus cycle: drive, sample mid-cycle, update scoreboard, advance past the edge.
  task automatic step(input logic [15:0] a, input logic [15:0] d, input logic wn,
                      input logic on, input logic rdy, input logic ck,
                      input logic [15:0] exp, input string nm);
    address = a; data_out = d; wren_n = wn; oen_n = on; out_ready = rdy;
    #2;
    chk("out_valid", {15'd0, out_valid}, {15'd0, q.size() != 0});
    if (ck) chk(nm, data_in, exp);
    if (q.size() != 0 && rdy) begin
      chk("fifo_head", out_data, q.pop_front());
    end
    if (!wn && on && a == 16'hFF00 && q.size() < 8) q.push_back(d);
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string nm);
    step(a, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, exp, nm);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic rdy);
    step(a, d, 1'b0, 1'b1, rdy, 1'b0, 16'h0, "");
  endtask

  initial begin
    vecs[0]  = '{16'h0010, 16'hBEEF, 1'b0, 1'b1, 1'b0, 16'h0000};
    vecs[1]  = '{16'h0010, 16'h0000, 1'b1, 1'b0, 1'b1, 16'hBEEF};
    vecs[2]  = '{16'h2000, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000};
    vecs[3]  = '{16'h0010, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0000};
    vecs[4]  = '{16'hFF03, 16'h5A5A, 1'b0, 1'b1, 1'b0, 16'h0000};
    vecs[5]  = '{16'hFF03, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h5A5A};
    vecs[6]  = '{16'hFF00, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000};
    vecs[7]  = '{16'hFF07, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000};
    vecs[8]  = '{16'hFF01, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0002};
    vecs[9]  = '{16'h0FFF, 16'h1357, 1'b0, 1'b1, 1'b0, 16'h0000};
    vecs[10] = '{16'h0FFF, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h1357};
    vecs[11] = '{16'h1000, 16'h2468, 1'b0, 1'b1, 1'b0, 16'h0000};
    vecs[12] = '{16'h1000, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000};
    vecs[13] = '{16'hFF07, 16'h9999, 1'b0, 1'b1, 1'b0, 16'h0000};
    vecs[14] = '{16'hFF03, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h5A5A};
    vecs[15] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h0000};
    vecs[16] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0001};
    vecs[17] = '{16'h0010, 16'h0000, 1'b1, 1'b0, 1'b1, 16'hBEEF};

    // Reset, reading STATUS throughout to see data_in stay live during reset.
    rst = 1'b1; address = 16'hFF01; data_out = 16'h0; wren_n = 1'b1; oen_n = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #3;
    chk("status_in_reset", data_in, 16'h0002);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_out_valid", {15'd0, out_valid}, 16'h0);
    chk("rst_out_data", out_data, 16'h0);
    chk("rst_bus_err", {15'd0, bus_err}, 16'h0);

    // Timer counts from 0 in the first cycle after reset.
    for (int k = 0; k < 5; k++) rd(16'hFF02, 16'(k), "timer_count");

    foreach (vecs[i])
      step(vecs[i].a, vecs[i].d, vecs[i].wn, vecs[i].on, 1'b0, vecs[i].ck, vecs[i].exp, "vector");

    // Timer load and wrap.
    wr(16'hFF02, 16'hFFFE, 1'b0);
    rd(16'hFF02, 16'hFFFE, "timer_load");
    rd(16'hFF02, 16'hFFFF, "timer_inc");
    rd(16'hFF02, 16'h0000, "timer_wrap");

    // FIFO fill, overflow, clear, push+pop while full, drain.
    for (int i = 1; i <= 8; i++) wr(16'hFF00, 16'(i), 1'b0);
    rd(16'hFF01, 16'h0081, "status_full");
    wr(16'hFF00, 16'h0009, 1'b0);
    rd(16'hFF01, 16'h0085, "status_ovf");
    wr(16'hFF01, 16'h0000, 1'b0);
    rd(16'hFF01, 16'h0081, "status_ovf_clr");
    wr(16'hFF00, 16'h00AA, 1'b1);
    rd(16'hFF01, 16'h0081, "status_push_pop_full");
    for (int i = 0; i < 10; i++) step(16'h0000, 16'h0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0, "");
    chk("drained", 16'(q.size()), 16'h0);
    rd(16'hFF01, 16'h0002, "status_drained");

    // Bus conflict.
    step(16'h0010, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 16'hBEEF, "conflict_read");
    chk("bus_err_set", {15'd0, bus_err}, 16'h1);
    rd(16'h0010, 16'hBEEF, "conflict_no_write");
    rd(16'hFF01, 16'h000A, "status_bus_err");
    wr(16'hFF01, 16'hFFFF, 1'b0);
    chk("bus_err_clr", {15'd0, bus_err}, 16'h0);
    rd(16'hFF01, 16'h0002, "status_after_clr");

    // Reset mid-stream with a handshake and a RAM write in the reset cycle.
    wr(16'hFF00, 16'hA001, 1'b0);
    wr(16'hFF00, 16'hA002, 1'b0);
    wr(16'hFF00, 16'hA003, 1'b0);
    rd(16'hFF01, 16'h0030, "status_three");
    rst = 1'b1; address = 16'h0010; data_out = 16'h1111; wren_n = 1'b0; oen_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    chk("midrst_out_valid", {15'd0, out_valid}, 16'h0);
    chk("midrst_out_data", out_data, 16'h0);
    rd(16'hFF02, 16'h0000, "midrst_timer");
    rd(16'hFF01, 16'h0002, "midrst_status");
    rd(16'h0010, 16'hBEEF, "midrst_ram");
    rd(16'hFF03, 16'h0000, "midrst_scratch");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
